// File: rtl/dice_alu_issue.sv
// Operand issue stage for dice_alu: registers operands, schedules writeback slots by latency,
// and captures each result with its tag. Optional statistics: define DICE_ALU_ISSUE_STATS_EN.
module dice_alu_issue #(
    parameter int DATA_W  = 32,
    parameter int TAG_W   = 6,
    parameter int LAT_MAX = 4,
    parameter int LAT_W   = $clog2(LAT_MAX + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_opcode,
    input  logic [DATA_W-1:0] in_op0,
    input  logic [DATA_W-1:0] in_op1,
    input  logic [DATA_W-1:0] in_op2,
    input  logic              in_pred,
    input  logic [LAT_W-1:0]  in_lat,
    input  logic [TAG_W-1:0]  in_tag,
    output logic [31:0]       alu_opcode,
    output logic [DATA_W-1:0] alu_in0,
    output logic [DATA_W-1:0] alu_in1,
    output logic [DATA_W-1:0] alu_in2,
    output logic              alu_in3,
    input  logic [DATA_W-1:0] alu_out0,
    output logic              res_valid,
    output logic [DATA_W-1:0] res_data,
    output logic [TAG_W-1:0]  res_tag,
    output logic              err_lat,
    output logic [31:0]       stat_issued,
    output logic [31:0]       stat_stall
);

    function automatic logic lat_bad(input logic [LAT_W-1:0] lat);
        return (lat == '0) || (lat > LAT_W'(LAT_MAX));
    endfunction

    function automatic logic [LAT_W-1:0] lat_clamp(input logic [LAT_W-1:0] lat);
        if (lat == '0)
            return LAT_W'(1);
        if (lat > LAT_W'(LAT_MAX))
            return LAT_W'(LAT_MAX);
        return lat;
    endfunction

    // pend[i]: a result reaches alu_out0 i cycles from now; the slot above LAT_MAX is always empty
    logic [LAT_MAX:0]   pend;
    logic [TAG_W-1:0]   ptag [LAT_MAX:0];
    logic [LAT_W-1:0]   lat_eff;
    logic               slot_busy;
    logic               accept;

    assign lat_eff = lat_clamp(in_lat);

    always_comb begin
        slot_busy = 1'b0;
        for (int i = 2; i <= LAT_MAX; i++) begin
            if (int'(lat_eff) + 1 == i)
                slot_busy = pend[i];
        end
    end

    assign in_ready = ~flush & ~slot_busy;
    assign accept   = in_valid & in_ready;

    // slot scheduler
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend <= '0;
            for (int i = 0; i <= LAT_MAX; i++)
                ptag[i] <= '0;
        end else begin
            for (int i = 0; i < LAT_MAX; i++) begin
                pend[i] <= pend[i+1];
                ptag[i] <= ptag[i+1];
            end
            pend[LAT_MAX] <= 1'b0;
            ptag[LAT_MAX] <= '0;
            if (accept) begin
                for (int i = 1; i <= LAT_MAX; i++) begin
                    if (int'(lat_eff) == i) begin
                        pend[i] <= 1'b1;
                        ptag[i] <= in_tag;
                    end
                end
            end
            if (flush)
                pend <= '0;
        end
    end

    // operand registers toward the ALU
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_opcode <= '0;
            alu_in0    <= '0;
            alu_in1    <= '0;
            alu_in2    <= '0;
            alu_in3    <= 1'b0;
        end else if (accept) begin
            alu_opcode <= in_opcode;
            alu_in0    <= in_op0;
            alu_in1    <= in_op1;
            alu_in2    <= in_op2;
            alu_in3    <= in_pred;
        end
    end

    // result capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid <= 1'b0;
            res_data  <= '0;
            res_tag   <= '0;
        end else begin
            res_valid <= pend[0] & ~flush;
            if (pend[0]) begin
                res_data <= alu_out0;
                res_tag  <= ptag[0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err_lat <= 1'b0;
        else if (accept && lat_bad(in_lat))
            err_lat <= 1'b1;
    end

`ifdef DICE_ALU_ISSUE_STATS_EN
    logic [31:0] issued_cnt;
    logic [31:0] stall_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issued_cnt <= '0;
            stall_cnt  <= '0;
        end else begin
            if (accept)
                issued_cnt <= issued_cnt + 32'd1;
            if (in_valid && !in_ready)
                stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign stat_issued = issued_cnt;
    assign stat_stall  = stall_cnt;
`else
    assign stat_issued = '0;
    assign stat_stall  = '0;
`endif

endmodule

// File: tb/tb_dice_alu_issue.sv
// Directed bench for dice_alu_issue with a small behavioural ALU (ADD latency 1, MAD latency 2).
module tb_dice_alu_issue;

    localparam int DATA_W = 32;
    localparam int TAG_W  = 6;
    localparam int LAT_W  = 3;
    localparam logic [31:0] OPC_ADD = 32'h0000_0001;
    localparam logic [31:0] OPC_MAD = 32'h0000_0002;
`ifdef DICE_ALU_ISSUE_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_opcode;
    logic [DATA_W-1:0] in_op0, in_op1, in_op2;
    logic              in_pred;
    logic [LAT_W-1:0]  in_lat;
    logic [TAG_W-1:0]  in_tag;
    logic [31:0]       alu_opcode;
    logic [DATA_W-1:0] alu_in0, alu_in1, alu_in2;
    logic              alu_in3;
    logic [DATA_W-1:0] alu_out0;
    logic              res_valid;
    logic [DATA_W-1:0] res_data;
    logic [TAG_W-1:0]  res_tag;
    logic              err_lat;
    logic [31:0]       stat_issued, stat_stall;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    dice_alu_issue #(.DATA_W(DATA_W), .TAG_W(TAG_W), .LAT_MAX(4)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
        .in_op0(in_op0), .in_op1(in_op1), .in_op2(in_op2), .in_pred(in_pred),
        .in_lat(in_lat), .in_tag(in_tag),
        .alu_opcode(alu_opcode), .alu_in0(alu_in0), .alu_in1(alu_in1),
        .alu_in2(alu_in2), .alu_in3(alu_in3), .alu_out0(alu_out0),
        .res_valid(res_valid), .res_data(res_data), .res_tag(res_tag),
        .err_lat(err_lat), .stat_issued(stat_issued), .stat_stall(stat_stall)
    );

    // Behavioural ALU: ADD result one cycle after its operands, MAD result two cycles after.
    logic [31:0]       s1_op;
    logic [DATA_W-1:0] s1_add, s1_mad, s2_mad;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_op  <= '0;
            s1_add <= '0;
            s1_mad <= '0;
            s2_mad <= '0;
        end else begin
            s1_op  <= alu_opcode;
            s1_add <= alu_in0 + alu_in1;
            s1_mad <= alu_in0 * alu_in1 + alu_in2;
            s2_mad <= s1_mad;
        end
    end
    assign alu_out0 = (s1_op == OPC_ADD) ? s1_add : s2_mad;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] opc, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] c, input logic [LAT_W-1:0] lat,
                         input logic [TAG_W-1:0] tag, input string name);
        in_valid  = 1'b1;
        in_opcode = opc;
        in_op0    = a;
        in_op1    = b;
        in_op2    = c;
        in_lat    = lat;
        in_tag    = tag;
        in_pred   = 1'b1;
        #1;
        check({name, "_ready"}, 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_opcode = '0;
        in_op0 = '0; in_op1 = '0; in_op2 = '0; in_pred = 1'b0; in_lat = '0; in_tag = '0;
        cyc(2);
        check("rst_res_valid", 64'(res_valid), 64'd0);
        check("rst_res_data", 64'(res_data), 64'd0);
        check("rst_alu_opcode", 64'(alu_opcode), 64'd0);
        check("rst_err_lat", 64'(err_lat), 64'd0);
        in_lat = 3'd4;
        #1;
        check("rst_ready_lat4", 64'(in_ready), 64'd1);
        rst_n = 1'b1;
        cyc(1);

        // ADD, L=1
        issue(OPC_ADD, 10, 20, 0, 3'd1, 6'd3, "add1");
        check("add1_alu_in0", 64'(alu_in0), 64'd10);
        check("add1_alu_opc", 64'(alu_opcode), 64'(OPC_ADD));
        check("add1_early", 64'(res_valid), 64'd0);
        cyc(2);
        check("add1_valid", 64'(res_valid), 64'd1);
        check("add1_data", 64'(res_data), 64'd30);
        check("add1_tag", 64'(res_tag), 64'd3);
        cyc(1);
        check("add1_oneshot", 64'(res_valid), 64'd0);
        check("add1_hold", 64'(res_data), 64'd30);

        // MAD, L=2
        issue(OPC_MAD, 2, 3, 4, 3'd2, 6'd5, "mad");
        cyc(2);
        check("mad_early", 64'(res_valid), 64'd0);
        cyc(1);
        check("mad_valid", 64'(res_valid), 64'd1);
        check("mad_data", 64'(res_data), 64'd10);
        check("mad_tag", 64'(res_tag), 64'd5);
        cyc(1);

        // collision: MAD then ADD one cycle later
        issue(OPC_MAD, 7, 2, 1, 3'd2, 6'd9, "col_mad");
        in_valid = 1'b1; in_opcode = OPC_ADD; in_op0 = 5; in_op1 = 6; in_lat = 3'd1; in_tag = 6'd10;
        #1;
        check("col_stall", 64'(in_ready), 64'd0);
        cyc(1);
        check("col_ready", 64'(in_ready), 64'd1);
        cyc(1);
        in_valid = 1'b0;
        check("col_stat_stall", 64'(stat_stall), STATS ? 64'd1 : 64'd0);
        check("col_none_yet", 64'(res_valid), 64'd0);
        cyc(1);
        check("col_mad_valid", 64'(res_valid), 64'd1);
        check("col_mad_data", 64'(res_data), 64'd15);
        check("col_mad_tag", 64'(res_tag), 64'd9);
        cyc(1);
        check("col_add_valid", 64'(res_valid), 64'd1);
        check("col_add_data", 64'(res_data), 64'd11);
        check("col_add_tag", 64'(res_tag), 64'd10);
        cyc(1);
        check("col_quiet", 64'(res_valid), 64'd0);

        // four back-to-back ADDs
        for (int c = 0; c < 6; c++) begin
            if (c < 4) begin
                in_valid = 1'b1; in_opcode = OPC_ADD; in_op0 = c + 1; in_op1 = c + 1;
                in_lat = 3'd1; in_tag = 6'(c);
                #1;
                check("b2b_ready", 64'(in_ready), 64'd1);
            end else begin
                in_valid = 1'b0;
            end
            cyc(1);
            check("b2b_valid", 64'(res_valid), (c >= 2) ? 64'd1 : 64'd0);
            if (c >= 2) begin
                check("b2b_data", 64'(res_data), 64'(2 * (c - 1)));
                check("b2b_tag", 64'(res_tag), 64'(c - 2));
            end
        end
        cyc(1);
        check("b2b_quiet", 64'(res_valid), 64'd0);

        // flush drops an in-flight MAD
        issue(OPC_MAD, 1, 1, 1, 3'd2, 6'd7, "fl_mad");
        flush = 1'b1;
        #1;
        check("fl_ready", 64'(in_ready), 64'd0);
        cyc(1);
        flush = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check("fl_no_res", 64'(res_valid), 64'd0);
            cyc(1);
        end
        check("fl_alu_keep", 64'(alu_opcode), 64'(OPC_MAD));
        issue(OPC_ADD, 100, 23, 0, 3'd1, 6'd12, "fl_add");
        cyc(2);
        check("fl_add_valid", 64'(res_valid), 64'd1);
        check("fl_add_data", 64'(res_data), 64'd123);
        check("fl_add_tag", 64'(res_tag), 64'd12);

        // latency range: 0 clamps to 1, 5 clamps to 4
        check("lat_err_before", 64'(err_lat), 64'd0);
        issue(OPC_ADD, 40, 2, 0, 3'd0, 6'd1, "lat0");
        check("lat0_err", 64'(err_lat), 64'd1);
        cyc(2);
        check("lat0_valid", 64'(res_valid), 64'd1);
        check("lat0_data", 64'(res_data), 64'd42);
        check("lat0_tag", 64'(res_tag), 64'd1);
        cyc(1);
        issue(OPC_ADD, 9, 8, 0, 3'd5, 6'd33, "lat5");
        cyc(4);
        check("lat5_early", 64'(res_valid), 64'd0);
        cyc(1);
        check("lat5_valid", 64'(res_valid), 64'd1);
        check("lat5_data", 64'(res_data), 64'd17);
        check("lat5_tag", 64'(res_tag), 64'd33);
        check("lat_err_sticky", 64'(err_lat), 64'd1);
        check("stat_issued", 64'(stat_issued), STATS ? 64'd12 : 64'd0);
        check("stat_stall_end", 64'(stat_stall), STATS ? 64'd1 : 64'd0);
        cyc(1);

        // reset mid-flight
        issue(OPC_MAD, 3, 3, 3, 3'd2, 6'd2, "rmf");
        rst_n = 1'b0;
        #1;
        check("rmf_err_clr", 64'(err_lat), 64'd0);
        check("rmf_stat_clr", 64'(stat_issued), 64'd0);
        check("rmf_alu_clr", 64'(alu_in0), 64'd0);
        cyc(1);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cyc(1);
            check("rmf_no_res", 64'(res_valid), 64'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/dice_alu_issue.md
# dice_alu_issue

Operand issue stage directly upstream of `dice_alu` in the CGRA ALU subsystem. Accepts operand tokens over a valid/ready handshake and drives registered operands, predicate and opcode into `dice_alu`. Tracks each operation's fixed pipeline latency so that no two results reach `alu_out0` in the same cycle. Captures each result with its tag on a single registered result port.

## Interface
Parameters:
- `DATA_W`, 32, operand/result width
- `TAG_W`, 6, result tag width
- `LAT_MAX`, 4, largest supported ALU latency in cycles (≥2)
- `LAT_W`, `$clog2(LAT_MAX+1)`, width of latency field

Ports:
- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `flush`  in  1  synchronous: drop all in-flight results
- `in_valid`  in  1  operand token valid
- `in_ready`  out  1  token accepted this edge when `in_valid & in_ready`
- `in_opcode`  in  32  ALU opcode (`dice_alu_pkg` encoding)
- `in_op0`, `in_op1`, `in_op2`  in  DATA_W  operands
- `in_pred`  in  1  predicate, forwarded to `alu_in3`
- `in_lat`  in  LAT_W  ALU latency of this opcode, supplied by the decoder (ADD class 1, MAD class 2)
- `in_tag`  in  TAG_W  destination tag
- `alu_opcode`  out  32  to `dice_alu.opcode`
- `alu_in0`, `alu_in1`, `alu_in2`  out  DATA_W  to `dice_alu.in0..in2`
- `alu_in3`  out  1  to `dice_alu.in3`
- `alu_out0`  in  DATA_W  from `dice_alu.out0`
- `res_valid`  out  1  one-cycle result strobe
- `res_data`  out  DATA_W  captured result
- `res_tag`  out  TAG_W  tag of captured result
- `err_lat`  out  1  sticky: out-of-range `in_lat` seen
- `stat_issued`, `stat_stall`  out  32  statistics counters (see Configuration)

## Operation
- Effective latency `L` = `in_lat` clamped into 1..LAT_MAX. If `in_lat` is 0 or greater than LAT_MAX, `err_lat` is set and the clamped value is used.
- Slot vector `pend[LAT_MAX+1:0]`, with a parallel tag array `ptag[LAT_MAX+1:0]`. `pend[LAT_MAX+1]` is constant 0.
- Every edge both arrays shift down by one: `pend[i] <= pend[i+1]`, and the same for `ptag`.
- On an accept, `pend[L]` is set and `ptag[L]` is set to `in_tag`.
- `pend[0]=1` means `alu_out0` holds a valid result in the current cycle.
- `in_ready = ~flush & ~pend[L+1]`. This is combinational on `in_lat` and has no dependency on `in_valid`. It blocks an issue whose result would land in an already-occupied writeback slot.
- On an accept, `alu_opcode/alu_in0..2/alu_in3` register `in_opcode/in_op0..2/in_pred`. They hold their value otherwise.
- Result capture every edge:
  - `res_valid <= pend[0] & ~flush`
  - `res_data <= alu_out0` and `res_tag <= ptag[0]` when `pend[0]`; otherwise both hold.
- No downstream backpressure: the consumer must take every `res_valid` strobe.
- `flush`: clears `pend` at the edge, forces `res_valid` to 0 at that edge and deasserts `in_ready` that cycle. `alu_*` registers keep their value.
- Results are returned in order of writeback slot, which is not necessarily issue order.

## Timing
- Reset (async, `rst_n=0`) sets `pend`, `ptag`, `alu_*`, `res_valid`, `res_data`, `res_tag`, `err_lat` and the counters to 0.
- After reset, `in_ready=1` for any `in_lat`. Upstream must hold `in_valid=0` during reset.
- Accept at edge E with latency L:
  - `alu_*` valid after E.
  - `alu_out0` valid after E+L.
  - `res_valid=1` in the cycle after E+L+1 (issue-to-result latency L+1).
- Same-latency operations issue back-to-back at one per cycle with no stall.
- An issue with latency L following a longer-latency issue stalls exactly until `pend[L+1]` clears.
- Reset mid-flight discards all pending results; no `res_valid` appears after reset release.

## Configuration
- `DICE_ALU_ISSUE_STATS_EN` defined:
  - `stat_issued` increments on every accept.
  - `stat_stall` increments on every cycle with `in_valid & ~in_ready`.
  - Both are 32-bit, wrap at 2^32, and are cleared by reset only (not by `flush`).
- Undefined: both ports are tied to 0 and no counter logic is built.

## Test plan
- ADD, L=1: `in_op0=10`, `in_op1=20`, tag 3, accepted at E -> `res_valid=1`, `res_data=30`, `res_tag=3` in the cycle after E+2, one cycle only.
- MAD, L=2: operands 2, 3, 4, tag 5, accepted at E -> `res_data=10`, `res_tag=5` in the cycle after E+3.
- Collision: MAD (L=2) accepted at E, ADD (L=1) presented at E+1 ->
  - `in_ready=0` for one cycle and ADD accepted at E+2.
  - MAD result after E+3, ADD result after E+4.
  - `stat_stall=1` with the macro defined.
- Four consecutive ADDs (1+1, 2+2, 3+3, 4+4) with tags 0..3 -> no stall, `res_data` 2, 4, 6, 8 on four consecutive cycles with matching tags.
- Flush: MAD accepted at E, `flush=1` during the cycle after E -> no `res_valid` for 5 cycles; the next ADD issues and returns normally.
- Latency range: `in_lat=0` on an ADD -> executes as L=1 with a correct result, and `err_lat` goes to 1 and stays set until `rst_n` is pulsed low.
